alarm_sequencer: RTL
====================

# alarm_sequencer

Measurement scheduler and intrusion decision unit for the ultrasonic alarm. It runs on the divided trigger clock and paces the HC-SR04 sensor controller with periodic start requests. It guards each measurement with a timeout and filters returned distances against a threshold, raising a latched alarm after a run of consecutive close readings. Arming and disarming come from a board switch.

## Interface
Parameters:
- EXIT_DELAY, 4: cycles between arming and the first measurement request (≥1).
- PERIOD, 8: idle cycles between the end of one measurement and the next request (≥1).
- TIMEOUT, 20: cycles in MEASURE without Meas_Done before the attempt is abandoned (≥1).
- HITS, 3: consecutive hits that raise the alarm (1..15).
- All cycle parameters must be < 2^16; internal cycle counter is 16 bits.

Ports:
- CLK  in  1  trigger-domain clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Arm  in  1  level from the switch, asynchronous; 1 = armed.
- Threshold  in  8  intrusion distance; quasi-static.
- Meas_Done  in  1  one-cycle pulse from the sensor controller; the measurement is complete.
- Distance_Raw  in  8  measured distance; valid in the Meas_Done cycle.
- Meas_Start  out  1  one-cycle request pulse to the sensor controller.
- Armed  out  1  high in every state except DISARMED.
- Alarm  out  1  latched alarm.
- Sensor_Fault  out  1  sticky flag; set when a measurement times out.
- Hit_Count  out  4  current consecutive-hit count.
- Last_Distance  out  8  most recent valid Distance_Raw.

## Operation
- Arm passes through a 2-flop synchroniser (Arm_s) before use.
- Reset:
  - State is DISARMED.
  - All outputs are 0.
  - Cycle counter is 0.
- States: DISARMED, EXIT, WAIT, MEASURE, ALARM.
- DISARMED: when Arm_s=1, go to EXIT and load counter = EXIT_DELAY-1.
- EXIT: decrement the counter. At counter 0, go to MEASURE.
- WAIT: decrement the counter. At counter 0, go to MEASURE.
- MEASURE:
  - Meas_Start=1 in the first MEASURE cycle only.
  - Counter starts at 0 and counts up.
  - Meas_Done is accepted in any MEASURE cycle, including the first.
- On an accepted Meas_Done:
  - Distance_Raw = 0 (no echo): the reading is invalid. Last_Distance and Hit_Count are unchanged.
  - Nonzero Distance_Raw is loaded into Last_Distance.
  - Hit when 0 < Distance_Raw < Threshold (strict). A hit increments Hit_Count.
  - Any other nonzero value is a miss. A miss clears Hit_Count.
  - If Hit_Count reaches HITS, go to ALARM with Alarm=1.
  - Otherwise go to WAIT with counter = PERIOD-1.
- Timeout: counter reaches TIMEOUT-1 with no Meas_Done.
  - Set Sensor_Fault=1.
  - Hit_Count is unchanged.
  - Go to WAIT with counter = PERIOD-1.
- Meas_Done in the same cycle as the timeout: Meas_Done wins and no fault is raised.
- ALARM:
  - Alarm and Hit_Count hold.
  - No further Meas_Start is issued.
  - Meas_Done is ignored.
- Meas_Done in DISARMED, EXIT or WAIT is ignored.
- Arm_s=0 in any state: next state is DISARMED. Alarm, Sensor_Fault and Hit_Count clear, Meas_Start is forced to 0. Last_Distance holds.
- Threshold = 0: no reading can hit.

## Timing
- All outputs are registered and change only on rising CLK edges, except the asynchronous reset.
- Arm rising to Armed=1: 3 cycles (2 synchroniser stages + 1 state register).
- Arm falling to Armed=0 and Alarm=0: 3 cycles.
- Arm_s rise to first Meas_Start: EXIT_DELAY+1 cycles.
- Accepted Meas_Done cycle, next edge:
  - Last_Distance and Hit_Count update.
  - Alarm rises if this reading is the HITS-th hit.
- Meas_Done to next Meas_Start: PERIOD+1 cycles.
- Meas_Start to timeout, with no done: Sensor_Fault rises TIMEOUT cycles after Meas_Start.
- Steady no-intrusion request spacing: (done latency within MEASURE) + PERIOD + 1.
- Reset asserted mid-measurement: a Meas_Start pulse in flight is truncated immediately. No state survives the reset.

## Test plan
Bench parameters: EXIT_DELAY=4, PERIOD=8, TIMEOUT=20, HITS=3; Threshold=50.
- Reset then arm: Arm=1 at cycle 0 → Armed=1 at cycle 3. Meas_Start single pulse at cycle 7. Outputs all 0 before arming.
- Three hits: respond to each start with Meas_Done and Distance 30, 30, 49 → Hit_Count 1, 2, 3. Alarm=1 on the edge after the third done, then no further Meas_Start for 100 cycles.
- Miss clears: readings 30, 30, 50 → Hit_Count 1, 2, 0, Alarm stays 0. Next Meas_Start arrives 9 cycles after each done.
- Invalid and timeout:
  - Distance 0 → Hit_Count and Last_Distance unchanged.
  - No Meas_Done → Sensor_Fault=1 exactly 20 cycles after Meas_Start, then a new Meas_Start 9 cycles later.
  - Meas_Done coincident with the timeout cycle → no fault.
- Disarm: drop Arm during ALARM → Alarm, Sensor_Fault and Hit_Count are 0 and Armed=0 three cycles later; Last_Distance retains 49. Re-arm restarts the EXIT delay.
- Async reset: assert RST_N=0 during a Meas_Start cycle and in the middle of MEASURE → outputs go to 0 without waiting for a clock edge. A stray Meas_Done afterwards has no effect.

Source files
------------

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: paces HC-SR04 measurements, times them out, and latches an intrusion alarm
// Ports:
//   CLK, RST_N          trigger-domain clock, asynchronous active-low reset
//   Arm                 asynchronous arm switch level (synchronised internally)
//   Threshold           intrusion distance; readings strictly below it (and nonzero) are hits
//   Meas_Done           one-cycle completion pulse from the sensor controller
//   Distance_Raw        measured distance, valid with Meas_Done; 0 means no echo
//   Meas_Start          one-cycle request pulse to the sensor controller
//   Armed               high in every state except DISARMED
//   Alarm               latched alarm
//   Sensor_Fault        sticky measurement-timeout flag
//   Hit_Count           consecutive-hit count
//   Last_Distance       most recent nonzero distance
module alarm_sequencer #(
  parameter int EXIT_DELAY = 4,
  parameter int PERIOD     = 8,
  parameter int TIMEOUT    = 20,
  parameter int HITS       = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Arm,
  input  logic [7:0] Threshold,
  input  logic       Meas_Done,
  input  logic [7:0] Distance_Raw,
  output logic       Meas_Start,
  output logic       Armed,
  output logic       Alarm,
  output logic       Sensor_Fault,
  output logic [3:0] Hit_Count,
  output logic [7:0] Last_Distance
);
  localparam logic [2:0] DISARMED = 3'd0;
  localparam logic [2:0] EXIT     = 3'd1;
  localparam logic [2:0] WAIT     = 3'd2;
  localparam logic [2:0] MEASURE  = 3'd3;
  localparam logic [2:0] ALARM    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        arm_m_q, arm_s_q;
  logic        start_q, start_d;
  logic        alarm_q, alarm_d;
  logic        fault_q, fault_d;
  logic        armed_q, armed_d;
  logic [3:0]  hits_q, hits_d;
  logic [7:0]  dist_q, dist_d;
  logic        valid, hit;
  logic [3:0]  hits_nxt;

  assign valid    = Distance_Raw != 8'd0;
  assign hit      = valid && (Distance_Raw < Threshold);
  assign hits_nxt = hit ? hits_q + 4'd1 : (valid ? 4'd0 : hits_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    fault_d = fault_q;
    hits_d  = hits_q;
    dist_d  = dist_q;
    if (!arm_s_q) begin
      state_d = DISARMED;
      cnt_d   = 16'd0;
      alarm_d = 1'b0;
      fault_d = 1'b0;
      hits_d  = 4'd0;
    end else begin
      case (state_q)
        DISARMED: begin
          state_d = EXIT;
          cnt_d   = 16'(EXIT_DELAY - 1);
        end
        EXIT, WAIT: begin
          state_d = (cnt_q == 16'd0) ? MEASURE : state_q;
          cnt_d   = (cnt_q == 16'd0) ? 16'd0 : cnt_q - 16'd1;
        end
        MEASURE: begin
          // A done arriving in the timeout cycle takes priority over the fault.
          if (Meas_Done) begin
            hits_d  = hits_nxt;
            dist_d  = valid ? Distance_Raw : dist_q;
            alarm_d = hit && (hits_nxt == 4'(HITS));
            state_d = alarm_d ? ALARM : WAIT;
            cnt_d   = 16'(PERIOD - 1);
          end else if (cnt_q == 16'(TIMEOUT - 1)) begin
            fault_d = 1'b1;
            state_d = WAIT;
            cnt_d   = 16'(PERIOD - 1);
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ALARM: state_d = ALARM;
        default: state_d = DISARMED;
      endcase
    end
    start_d = (state_d == MEASURE) && (state_q != MEASURE);
    armed_d = state_d != DISARMED;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      arm_m_q <= 1'b0;
      arm_s_q <= 1'b0;
      state_q <= DISARMED;
      cnt_q   <= 16'd0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      alarm_q <= 1'b0;
      fault_q <= 1'b0;
      hits_q  <= 4'd0;
      dist_q  <= 8'd0;
    end else begin
      arm_m_q <= Arm;
      arm_s_q <= arm_m_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      armed_q <= armed_d;
      alarm_q <= alarm_d;
      fault_q <= fault_d;
      hits_q  <= hits_d;
      dist_q  <= dist_d;
    end
  end

  assign Meas_Start    = start_q;
  assign Armed         = armed_q;
  assign Alarm         = alarm_q;
  assign Sensor_Fault  = fault_q;
  assign Hit_Count     = hits_q;
  assign Last_Distance = dist_q;
endmodule
